// File: rtl/pc_redirect_ctrl_pkg.sv
// rtl/pc_redirect_ctrl_pkg.sv - shared types and constants for the fetch PC redirect controller
package pc_redirect_ctrl_pkg;

  localparam int XLEN_DEFAULT = 64;

  // Shared with the PC register so both agree on where fetch starts after reset.
  localparam logic [63:0] RESET_VECTOR = 64'h0000_0000_8000_0000;

  typedef enum logic [2:0] {
    PCR_IDLE      = 3'd0,
    PCR_TRAP_WB   = 3'd1,
    PCR_DRAIN     = 3'd2,
    PCR_TRAP_JUMP = 3'd3,
    PCR_MRET_JUMP = 3'd4
  } pcr_state_t;

  // Drain counter width; stays at least 1 bit so a zero-cycle drain still elaborates.
  function automatic int pcr_cnt_width(input int flush_cycles);
    if (flush_cycles < 1) begin
      return 1;
    end
    return $clog2(flush_cycles + 1);
  endfunction

endpackage

// File: rtl/pcr_drain_counter.sv
// rtl/pcr_drain_counter.sv - loadable down-counter timing the trap drain phase
module pcr_drain_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // The last drain cycle is the one that still sees a count of 1.
  assign o_done = (r_count == W'(1));

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - arbitrates branch, stall, trap and mret requests into PC controls
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_rel_branch,
  input  logic            ex_abs_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            hazard_stall,
  input  logic            exc_req,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_cause,
  input  logic            mret_req,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic [XLEN-1:0] csr_mtvec,
  output logic            pc_rel_branch,
  output logic            pc_abs_branch,
  output logic            pc_exception,
  output logic            pc_bubble,
  output logic [XLEN-1:0] pc_ref_pc,
  output logic [XLEN-1:0] pc_immediate,
  output logic [XLEN-1:0] pc_mtvec,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            csr_mepc_we,
  output logic            csr_mcause_we,
  output logic [XLEN-1:0] csr_mepc_wdata,
  output logic [XLEN-1:0] csr_mcause_wdata,
  output logic            busy
);

  localparam int CNT_W = pcr_cnt_width(FLUSH_CYCLES);

  pcr_state_t      r_state;
  pcr_state_t      w_state_nxt;
  logic [XLEN-1:0] r_exc_pc;
  logic [XLEN-1:0] r_exc_cause;
  logic            w_drain_done;
  logic            w_idle;

  assign w_idle = (r_state == PCR_IDLE);

  pcr_drain_counter #(
    .W (CNT_W)
  ) u_drain_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_state == PCR_TRAP_WB),
    .i_load_val (CNT_W'(FLUSH_CYCLES)),
    .i_dec      (r_state == PCR_DRAIN),
    .o_done     (w_drain_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PCR_IDLE: begin
        if (exc_req) begin
          w_state_nxt = PCR_TRAP_WB;
        end else if (mret_req) begin
          w_state_nxt = PCR_MRET_JUMP;
        end
      end
      PCR_TRAP_WB:   w_state_nxt = (FLUSH_CYCLES == 0) ? PCR_TRAP_JUMP : PCR_DRAIN;
      PCR_DRAIN:     w_state_nxt = w_drain_done ? PCR_TRAP_JUMP : PCR_DRAIN;
      PCR_TRAP_JUMP: w_state_nxt = PCR_IDLE;
      PCR_MRET_JUMP: w_state_nxt = PCR_IDLE;
      default:       w_state_nxt = PCR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= PCR_IDLE;
      r_exc_pc    <= '0;
      r_exc_cause <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_idle && exc_req) begin
        r_exc_pc    <= exc_pc;
        r_exc_cause <= exc_cause;
      end
    end
  end

  // Outputs are forced low while rst is high so a mid-sequence reset never leaks a jump or CSR write.
  always_comb begin
    pc_rel_branch    = 1'b0;
    pc_abs_branch    = 1'b0;
    pc_exception     = 1'b0;
    pc_bubble        = 1'b0;
    pc_ref_pc        = '0;
    pc_immediate     = '0;
    pc_mtvec         = '0;
    flush_if_id      = 1'b0;
    flush_id_ex      = 1'b0;
    csr_mepc_we      = 1'b0;
    csr_mcause_we    = 1'b0;
    csr_mepc_wdata   = '0;
    csr_mcause_wdata = '0;
    busy             = 1'b0;
    if (!rst) begin
      busy = !w_idle;
      case (r_state)
        PCR_IDLE: begin
          if (exc_req || mret_req) begin
            pc_bubble   = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (ex_rel_branch) begin
            pc_rel_branch = 1'b1;
            pc_ref_pc     = ex_pc;
            pc_immediate  = ex_target;
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
          end else if (ex_abs_branch) begin
            pc_abs_branch = 1'b1;
            pc_immediate  = ex_target;
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
          end else if (hazard_stall) begin
            pc_bubble = 1'b1;
          end
        end
        PCR_TRAP_WB: begin
          csr_mepc_we      = 1'b1;
          csr_mcause_we    = 1'b1;
          csr_mepc_wdata   = r_exc_pc;
          csr_mcause_wdata = r_exc_cause;
          pc_bubble        = 1'b1;
          flush_if_id      = 1'b1;
          flush_id_ex      = 1'b1;
        end
        PCR_DRAIN: begin
          pc_bubble   = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
        PCR_TRAP_JUMP: begin
          pc_exception = 1'b1;
          pc_mtvec     = csr_mtvec;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
        end
        PCR_MRET_JUMP: begin
          pc_abs_branch = 1'b1;
          pc_immediate  = csr_mepc;
          flush_if_id   = 1'b1;
          flush_id_ex   = 1'b1;
        end
        default: begin
          busy = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;
  import pc_redirect_ctrl_pkg::*;

  localparam int XL = 64;
  localparam int FC = 2;

  localparam int K_WB  = 0;
  localparam int K_BUB = 1;
  localparam int K_TJ  = 2;
  localparam int K_MJ  = 3;

  typedef struct packed {
    logic          rst, exc, mret, rel, abs, stall;
    logic [XL-1:0] ex_pc, ex_target, exc_pc, exc_cause, mepc, mtvec;
  } in_t;

  typedef struct packed {
    logic          rel, abs, exc, bubble;
    logic [XL-1:0] ref_pc, imm, mtvec;
    logic          fif, fid, mepc_we, mcause_we;
    logic [XL-1:0] mepc_wd, mcause_wd;
    logic          busy;
  } out_t;

  typedef struct {
    int            kind;
    logic [XL-1:0] a, b;
  } pend_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic ex_rel_branch, ex_abs_branch, hazard_stall, exc_req, mret_req;
  logic [XL-1:0] ex_pc, ex_target, exc_pc, exc_cause, csr_mepc, csr_mtvec;
  logic pc_rel_branch, pc_abs_branch, pc_exception, pc_bubble;
  logic [XL-1:0] pc_ref_pc, pc_immediate, pc_mtvec;
  logic flush_if_id, flush_id_ex, csr_mepc_we, csr_mcause_we, busy;
  logic [XL-1:0] csr_mepc_wdata, csr_mcause_wdata;
  logic [XL-1:0] pc;

  int    errors = 0;
  int    checks = 0;
  pend_t q[$];
  out_t  got;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.XLEN(XL), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .ex_rel_branch(ex_rel_branch), .ex_abs_branch(ex_abs_branch),
    .ex_pc(ex_pc), .ex_target(ex_target), .hazard_stall(hazard_stall),
    .exc_req(exc_req), .exc_pc(exc_pc), .exc_cause(exc_cause), .mret_req(mret_req),
    .csr_mepc(csr_mepc), .csr_mtvec(csr_mtvec),
    .pc_rel_branch(pc_rel_branch), .pc_abs_branch(pc_abs_branch),
    .pc_exception(pc_exception), .pc_bubble(pc_bubble),
    .pc_ref_pc(pc_ref_pc), .pc_immediate(pc_immediate), .pc_mtvec(pc_mtvec),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .csr_mepc_we(csr_mepc_we), .csr_mcause_we(csr_mcause_we),
    .csr_mepc_wdata(csr_mepc_wdata), .csr_mcause_wdata(csr_mcause_wdata),
    .busy(busy)
  );

  // Stand-in for the downstream PC register, used to check where fetch ends up.
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_VECTOR;
    else if (pc_exception) pc <= pc_mtvec;
    else if (pc_rel_branch) pc <= pc_ref_pc + pc_immediate;
    else if (pc_abs_branch) pc <= pc_immediate;
    else if (!pc_bubble) pc <= pc + 64'd4;
  end

  function automatic out_t get_out();
    out_t o;
    o.rel = pc_rel_branch; o.abs = pc_abs_branch; o.exc = pc_exception; o.bubble = pc_bubble;
    o.ref_pc = pc_ref_pc; o.imm = pc_immediate; o.mtvec = pc_mtvec;
    o.fif = flush_if_id; o.fid = flush_id_ex;
    o.mepc_we = csr_mepc_we; o.mcause_we = csr_mcause_we;
    o.mepc_wd = csr_mepc_wdata; o.mcause_wd = csr_mcause_wdata;
    o.busy = busy;
    return o;
  endfunction

  function automatic out_t mk_out(input logic rel, input logic abs, input logic bub,
                                  input logic [XL-1:0] rpc, input logic [XL-1:0] imm, input logic fl);
    out_t o;
    o = '0;
    o.rel = rel; o.abs = abs; o.bubble = bub; o.ref_pc = rpc; o.imm = imm; o.fif = fl; o.fid = fl;
    return o;
  endfunction

  // Schedule-based reference: an accepted trap or mret enqueues the cycles it will occupy.
  task automatic model_step(input in_t in, output out_t e);
    pend_t p;
    e = '0;
    if (in.rst) begin
      q.delete();
      return;
    end
    if (q.size() > 0) begin
      p = q.pop_front();
      e.busy = 1'b1; e.fif = 1'b1; e.fid = 1'b1;
      case (p.kind)
        K_WB: begin
          e.bubble = 1'b1; e.mepc_we = 1'b1; e.mcause_we = 1'b1; e.mepc_wd = p.a; e.mcause_wd = p.b;
        end
        K_BUB: e.bubble = 1'b1;
        K_TJ: begin e.exc = 1'b1; e.mtvec = in.mtvec; end
        default: begin e.abs = 1'b1; e.imm = in.mepc; end
      endcase
    end else if (in.exc) begin
      e.bubble = 1'b1; e.fif = 1'b1; e.fid = 1'b1;
      q.push_back('{K_WB, in.exc_pc, in.exc_cause});
      for (int i = 0; i < FC; i++) q.push_back('{K_BUB, '0, '0});
      q.push_back('{K_TJ, '0, '0});
    end else if (in.mret) begin
      e.bubble = 1'b1; e.fif = 1'b1; e.fid = 1'b1;
      q.push_back('{K_MJ, '0, '0});
    end else if (in.rel) begin
      e.rel = 1'b1; e.ref_pc = in.ex_pc; e.imm = in.ex_target; e.fif = 1'b1; e.fid = 1'b1;
    end else if (in.abs) begin
      e.abs = 1'b1; e.imm = in.ex_target; e.fif = 1'b1; e.fid = 1'b1;
    end else if (in.stall) begin
      e.bubble = 1'b1;
    end
  endtask

  task automatic drive(input in_t in);
    rst = in.rst; exc_req = in.exc; mret_req = in.mret;
    ex_rel_branch = in.rel; ex_abs_branch = in.abs; hazard_stall = in.stall;
    ex_pc = in.ex_pc; ex_target = in.ex_target; exc_pc = in.exc_pc; exc_cause = in.exc_cause;
    csr_mepc = in.mepc; csr_mtvec = in.mtvec;
  endtask

  task automatic chk_out(input string name, input out_t g, input out_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, g, e);
    end
  endtask

  task automatic chk_val(input string name, input logic [XL-1:0] g, input logic [XL-1:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, g, e);
    end
  endtask

  task automatic cycle(input in_t in, input string name);
    out_t e;
    drive(in);
    model_step(in, e);
    @(negedge clk);
    got = get_out();
    chk_out(name, got, e);
    @(posedge clk);
    #1;
  endtask

  in_t  b, t;
  vec_t vecs[$];
  out_t e_unused;
  int   seen;

  initial begin
    b = '0;
    b.mtvec = 64'h8000_1000;
    b.mepc  = 64'h8000_0044;

    t = b; t.rst = 1'b1;
    drive(t);
    @(posedge clk); #1;
    cycle(t, "reset_outputs_zero");
    cycle(b, "first_idle_zero");
    chk_val("pc_after_idle", pc, 64'h8000_0004);

    // Single-cycle IDLE arbitration vectors with hand-written expectations.
    t = b; t.rst = 1'b1; t.exc = 1; t.mret = 1; t.rel = 1; t.abs = 1; t.stall = 1; t.ex_target = 64'h55;
    vecs.push_back('{"rst_masks_all", t, mk_out(0, 0, 0, '0, '0, 0)});
    t = b;
    vecs.push_back('{"idle_none", t, mk_out(0, 0, 0, '0, '0, 0)});
    t = b; t.stall = 1;
    vecs.push_back('{"stall_only", t, mk_out(0, 0, 1, '0, '0, 0)});
    t = b; t.abs = 1; t.ex_target = 64'h8000_0200; t.ex_pc = 64'h8000_0100;
    vecs.push_back('{"abs_only", t, mk_out(0, 1, 0, '0, 64'h8000_0200, 1)});
    t = b; t.abs = 1; t.stall = 1; t.ex_target = 64'hFFFF_FFFF_FFFF_FFF0;
    vecs.push_back('{"abs_over_stall", t, mk_out(0, 1, 0, '0, 64'hFFFF_FFFF_FFFF_FFF0, 1)});
    t = b; t.rel = 1; t.abs = 1; t.ex_pc = 64'h8000_0020; t.ex_target = 64'hFFFF_FFFF_FFFF_FFFC;
    vecs.push_back('{"rel_over_abs", t, mk_out(1, 0, 0, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFC, 1)});
    foreach (vecs[i]) begin
      drive(vecs[i].in);
      model_step(vecs[i].in, e_unused);
      @(negedge clk);
      chk_out(vecs[i].name, get_out(), vecs[i].exp);
      @(posedge clk); #1;
    end

    // Relative branch beats a same-cycle stall.
    t = b; t.rel = 1; t.stall = 1; t.ex_pc = 64'h8000_0010; t.ex_target = 64'h20;
    cycle(t, "rel_with_stall");
    chk_val("pc_after_rel", pc, 64'h8000_0030);

    // Trap entry, with requests arriving while busy that must be dropped.
    t = b; t.exc = 1; t.exc_pc = 64'h8000_0040; t.exc_cause = 64'd2;
    cycle(t, "exc_accept");
    chk_val("exc_T_bubble", {63'd0, got.bubble}, 64'd1);
    cycle(b, "exc_wb");
    chk_val("csr_mepc_wdata", got.mepc_we ? got.mepc_wd : 64'hDEAD, 64'h8000_0040);
    chk_val("csr_mcause_wdata", got.mcause_we ? got.mcause_wd : 64'hDEAD, 64'd2);
    t = b; t.rel = 1; t.ex_pc = 64'h1234; t.ex_target = 64'h10;
    cycle(t, "drain1_rel_dropped");
    t = b; t.mret = 1;
    cycle(t, "drain2_mret_dropped");
    chk_val("drain2_bubble", {63'd0, got.bubble}, 64'd1);
    t = b; t.exc = 1; t.exc_pc = 64'h99;
    cycle(t, "trap_jump_exc_ignored");
    chk_val("trap_jump_pc_exception", {63'd0, got.exc}, 64'd1);
    chk_val("pc_at_mtvec", pc, 64'h8000_1000);
    cycle(b, "after_trap_idle");

    // Trap, mret and absolute jump together: only the trap sequence may appear.
    t = b; t.exc = 1; t.mret = 1; t.abs = 1; t.exc_pc = 64'h8000_0060; t.exc_cause = 64'd11; t.ex_target = 64'h4444;
    seen = 0;
    cycle(t, "triple_accept");
    for (int i = 0; i < FC + 3; i++) begin
      cycle(b, "triple_follow");
      if (got.abs) seen++;
    end
    chk_val("triple_no_abs", 64'(seen), 64'd0);

    // mret, with an exception offered during MRET_JUMP.
    t = b; t.mret = 1;
    cycle(t, "mret_accept");
    t = b; t.exc = 1;
    cycle(t, "mret_jump");
    chk_val("mret_imm", got.abs ? got.imm : 64'hDEAD, 64'h8000_0044);
    chk_val("mret_busy", {63'd0, got.busy}, 64'd1);
    chk_val("pc_after_mret", pc, 64'h8000_0044);
    cycle(b, "mret_done_idle");

    // Reset while draining cancels the pending vector jump.
    t = b; t.exc = 1; t.exc_pc = 64'h8000_0080; t.exc_cause = 64'd5;
    cycle(t, "rst_seq_accept");
    cycle(b, "rst_seq_wb");
    cycle(b, "rst_seq_drain");
    t = b; t.rst = 1;
    cycle(t, "rst_in_drain");
    seen = 0;
    for (int i = 0; i < FC + 4; i++) begin
      cycle(b, "after_rst_idle");
      if (got.exc || got.mepc_we) seen++;
    end
    chk_val("rst_no_jump", 64'(seen), 64'd0);

    // Randomised traffic against the schedule model.
    for (int i = 0; i < 600; i++) begin
      t.rst       = ($urandom_range(0, 99) < 2);
      t.exc       = ($urandom_range(0, 19) == 0);
      t.mret      = ($urandom_range(0, 14) == 0);
      t.rel       = ($urandom_range(0, 3) == 0);
      t.abs       = ($urandom_range(0, 3) == 0);
      t.stall     = ($urandom_range(0, 2) == 0);
      t.ex_pc     = {$urandom, $urandom};
      t.ex_target = {$urandom, $urandom};
      t.exc_pc    = {$urandom, $urandom};
      t.exc_cause = {$urandom, $urandom};
      t.mepc      = {$urandom, $urandom};
      t.mtvec     = {$urandom, $urandom};
      cycle(t, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequencer for the fetch program counter. It merges redirect requests from execute (relative/absolute branches), the hazard unit (stall), the trap logic (exception entry) and `mret` into the single-cycle control inputs of the PC register. It runs the multi-cycle trap-entry sequence (CSR capture, pipeline drain, vector jump) and pulses pipeline flushes. It sits between execute/CSR and the PC register, and drives the PC's `rel_branch`, `abs_branch`, `exception`, `bubble`, `ref_pc`, `immediate` and `mtvec` inputs.

## Interface
- `XLEN`, 64, datapath width
- `FLUSH_CYCLES`, 2, drain cycles before the trap vector jump; 0 is legal
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `ex_rel_branch`  in  1  taken PC-relative branch/jal from execute
- `ex_abs_branch`  in  1  taken absolute jump (jalr) from execute
- `ex_pc`  in  XLEN  PC of the branching instruction
- `ex_target`  in  XLEN  offset (relative) or target (absolute)
- `hazard_stall`  in  1  hold fetch PC this cycle
- `exc_req`  in  1  exception raised by the pipeline
- `exc_pc`  in  XLEN  faulting PC
- `exc_cause`  in  XLEN  mcause value
- `mret_req`  in  1  mret retiring
- `csr_mepc`, `csr_mtvec`  in  XLEN  current CSR values
- `pc_rel_branch`, `pc_abs_branch`, `pc_exception`, `pc_bubble`  out  1  PC controls
- `pc_ref_pc`, `pc_immediate`, `pc_mtvec`  out  XLEN  PC operands
- `flush_if_id`, `flush_id_ex`  out  1  squash pipeline registers
- `csr_mepc_we`, `csr_mcause_we`  out  1  CSR write strobes
- `csr_mepc_wdata`, `csr_mcause_wdata`  out  XLEN  CSR write data
- `busy`  out  1  controller not in IDLE

## Operation
- States: IDLE, TRAP_WB, DRAIN, TRAP_JUMP, MRET_JUMP.
- IDLE accept priority: `exc_req` > `mret_req` > `ex_rel_branch` > `ex_abs_branch` > `hazard_stall`. Lower-priority requests in the same cycle are dropped.
- IDLE exception:
  - Capture `exc_pc` and `exc_cause` into internal registers.
  - Assert `pc_bubble`, `flush_if_id` and `flush_id_ex`.
  - Go to TRAP_WB.
- TRAP_WB (1 cycle):
  - `csr_mepc_we` = `csr_mcause_we` = 1, with write data from the captured registers.
  - Assert `pc_bubble` and both flushes.
  - Go to DRAIN, or to TRAP_JUMP if `FLUSH_CYCLES` = 0.
- DRAIN (`FLUSH_CYCLES` cycles, down-counter):
  - Assert `pc_bubble` and both flushes.
  - Go to TRAP_JUMP when the counter reaches 1.
- TRAP_JUMP (1 cycle): `pc_exception` = 1, `pc_mtvec` = `csr_mtvec`, flushes asserted; then IDLE.
- IDLE mret: assert `pc_bubble` and flushes; go to MRET_JUMP.
- MRET_JUMP (1 cycle): `pc_abs_branch` = 1, `pc_immediate` = `csr_mepc`, flushes asserted; then IDLE.
- IDLE relative branch: `pc_rel_branch` = 1, `pc_ref_pc` = `ex_pc`, `pc_immediate` = `ex_target`; both flushes pulse. Same cycle, combinational.
- IDLE absolute branch: `pc_abs_branch` = 1, `pc_immediate` = `ex_target`; both flushes pulse.
- IDLE stall: `pc_bubble` = 1, no flush.
- Non-IDLE: all requests are ignored (dropped, not queued); `busy` = 1. The pipeline is squashed, so dropped requests are stale by construction.
- At most one of `pc_rel_branch`, `pc_abs_branch` and `pc_exception` is high in any cycle.
- Outputs not in use are driven to 0.

## Timing
- Reset value: state IDLE, drain counter 0, captured registers 0. Every output is 0 while `rst` = 1 and during the first IDLE cycle with no requests.
- Branch/stall latency: controls are combinational in the request cycle, so the PC updates at the next edge.
- Exception accepted at cycle T:
  - CSR writes at T+1.
  - `pc_exception` at T+2+`FLUSH_CYCLES`.
  - PC equals `mtvec` after that edge.
  - `busy` is high from T+1 through T+2+`FLUSH_CYCLES`.
- mret accepted at T: `pc_abs_branch` at T+1. The one-cycle gap lets a same-cycle `mepc` CSR write settle.
- `rst` asserted mid-sequence: state returns to IDLE at the next edge; no CSR write or jump is issued afterward.
- `exc_req` in the TRAP_JUMP or MRET_JUMP cycle is ignored.

## Structure
- Shared package holds:
  - State enum `pcr_state_t` (3-bit encoding).
  - `XLEN` default.
  - `RESET_VECTOR` (0x0000_0000_8000_0000), shared with the PC register.
- One sub-module, `pcr_drain_counter`: loadable down-counter with a `done` flag, width $clog2(`FLUSH_CYCLES`+1), minimum 1.
- Arbitration and output muxing stay in the top module.

## Test plan
- Reset, then idle: all outputs 0; PC advances +4 from 0x8000_0000.
- `ex_rel_branch` with `ex_pc`=0x8000_0010 and `ex_target`=0x20, same cycle as `hazard_stall` → `pc_rel_branch`=1, `pc_ref_pc`=0x8000_0010, `pc_bubble`=0, flushes=1; PC reads 0x8000_0030 next cycle.
- `exc_req` with `exc_pc`=0x8000_0040, cause=2, `csr_mtvec`=0x8000_1000, `FLUSH_CYCLES`=2:
  - CSR writes of 0x8000_0040 and 2 at T+1.
  - Bubble at T..T+3.
  - `pc_exception` at T+4; PC reads 0x8000_1000 at T+5.
- `exc_req`, `mret_req` and `ex_abs_branch` together → only the trap sequence runs; no abs/mret output ever appears.
- `mret_req` with `csr_mepc`=0x8000_0044 → `pc_abs_branch` at T+1 with `pc_immediate`=0x8000_0044; `busy` high for 1 cycle.
- `rst` asserted in DRAIN → IDLE; `pc_exception` never asserts; outputs 0.
